// File: rtl/instruction_fetch.sv
// Fetch stage: reads four sequential flash bytes, assembles a little-endian
// 32-bit instruction and offers it downstream on a valid/ready handshake.
module instruction_fetch #(
   parameter int                    ADDR_WIDTH   = 24,
   parameter int                    READ_LATENCY = 3,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  flash_re,
   output logic [ADDR_WIDTH-1:0] flash_addr,
   input  logic [7:0]            flash_out,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

   localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [1:0]            byte_idx;
   logic [2:0]            lat_cnt;
   logic                  byte_done;
   logic                  transfer;

   assign byte_done  = (state == READ) && (lat_cnt == LAST_CNT);
   assign transfer   = (state == HOLD) && instr_valid && instr_ready;
   assign flash_re   = (state == READ);
   assign busy       = (state != IDLE);
   // The address wraps naturally because the sum is truncated to ADDR_WIDTH.
   assign flash_addr = (state == READ) ? pc + ADDR_WIDTH'(byte_idx) : '0;

   always_comb begin
      // NOTE: next state defaults to the current state so no path infers a latch.
      state_next = state;
      unique case (state)
         IDLE:    if (fetch_en) state_next = READ;
         READ:    if (byte_done && byte_idx == 2'd3) state_next = HOLD;
         HOLD:    if (transfer) state_next = fetch_en ? READ : IDLE;
         default: state_next = IDLE;
      endcase
      // A redirect restarts the walk regardless of where the sequencer was.
      if (redirect) state_next = fetch_en ? READ : IDLE;
   end

   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_VECTOR;
         byte_idx    <= '0;
         lat_cnt     <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (redirect) begin
            pc          <= redirect_addr;
            byte_idx    <= '0;
            lat_cnt     <= '0;
            instr_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  byte_idx <= '0;
                  lat_cnt  <= '0;
               end
               READ: begin
                  if (byte_done) begin
                     instr[{byte_idx, 3'b000} +: 8] <= flash_out;
                     byte_idx <= byte_idx + 2'd1;
                     lat_cnt  <= '0;
                     if (byte_idx == 2'd3) begin
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                     end
                  end else begin
                     lat_cnt <= lat_cnt + 3'd1;
                  end
               end
               HOLD: begin
                  if (transfer) begin
                     pc          <= pc + ADDR_WIDTH'(4);
                     instr_valid <= 1'b0;
                     byte_idx    <= '0;
                     lat_cnt     <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with latency-checking flash models for
// a default instance and a wrap-around instance (RESET_VECTOR = FFFFFE).
module tb_instruction_fetch;

   localparam int L = 3;

   logic        clk = 1'b0;
   logic        reset, fetch_en, redirect, instr_ready;
   logic [23:0] redirect_addr;

   logic        flash_re, instr_valid, busy;
   logic [23:0] flash_addr, instr_pc;
   logic [7:0]  flash_out;
   logic [31:0] instr;

   logic        w_flash_re, w_instr_valid, w_busy;
   logic [23:0] w_flash_addr, w_instr_pc;
   logic [7:0]  w_flash_out;
   logic [31:0] w_instr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instruction_fetch #(.ADDR_WIDTH(24), .READ_LATENCY(L), .RESET_VECTOR(24'h000000)) u_dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_addr(redirect_addr), .flash_re(flash_re), .flash_addr(flash_addr),
      .flash_out(flash_out), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy));

   instruction_fetch #(.ADDR_WIDTH(24), .READ_LATENCY(L), .RESET_VECTOR(24'hFFFFFE)) u_wrap (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_addr(redirect_addr), .flash_re(w_flash_re), .flash_addr(w_flash_addr),
      .flash_out(w_flash_out), .instr(w_instr), .instr_pc(w_instr_pc),
      .instr_valid(w_instr_valid), .instr_ready(instr_ready), .busy(w_busy));

   function automatic logic [7:0] main_byte(input logic [23:0] a);
      logic [31:0] w;
      if (a[23:4] != 20'h0) return 8'h00;
      case (a[3:2])
         2'd0: w = 32'h00100283;
         2'd1: w = 32'h00200303;
         2'd2: w = 32'h006283b3;
         default: w = 32'h007001a3;
      endcase
      return 8'(w >> (8 * a[1:0]));
   endfunction

   function automatic logic [7:0] wrap_byte(input logic [23:0] a);
      case (a)
         24'hFFFFFE: return 8'h78;
         24'hFFFFFF: return 8'h56;
         24'h000000: return 8'h34;
         24'h000001: return 8'h12;
         default:    return 8'h00;
      endcase
   endfunction

   // Flash models: data is only valid once the address has been held L cycles.
   logic        m_prev_re, w_prev_re;
   logic [23:0] m_addr_q, w_addr_q;
   int          m_held, w_held, m_cur, w_cur;

   always_comb begin
      m_cur = 0;
      if (flash_re) m_cur = (m_prev_re && flash_addr == m_addr_q) ? m_held + 1 : 1;
      w_cur = 0;
      if (w_flash_re) w_cur = (w_prev_re && w_flash_addr == w_addr_q) ? w_held + 1 : 1;
   end

   assign flash_out   = (m_cur >= L) ? main_byte(flash_addr) : 8'hEE;
   assign w_flash_out = (w_cur >= L) ? wrap_byte(w_flash_addr) : 8'hEE;

   always @(posedge clk) begin
      m_prev_re <= flash_re;
      m_addr_q  <= flash_addr;
      m_held    <= m_cur;
      w_prev_re <= w_flash_re;
      w_addr_q  <= w_flash_addr;
      w_held    <= w_cur;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input bit wrap, output int cyc);
      logic v;
      cyc = 0;
      do begin
         tick();
         cyc++;
         v = wrap ? w_instr_valid : instr_valid;
      end while (!v && cyc < 40);
      checks++;
      if (!v) begin
         errors++;
         $display("FAIL wait_valid timeout: instr_valid=%b after %0d cycles, required 1", v, cyc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
      tick();
      checks++;
      if ({flash_re, flash_addr, instr, instr_pc, instr_valid, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: re=%b addr=%h instr=%h pc=%h v=%b busy=%b, required all 0",
                  flash_re, flash_addr, instr, instr_pc, instr_valid, busy);
      end
      checks++;
      if ({w_flash_re, w_flash_addr, w_instr, w_instr_pc, w_instr_valid, w_busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_wrap: re=%b addr=%h pc=%h, required all 0",
                  w_flash_re, w_flash_addr, w_instr_pc);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp_i [4] = '{32'h00100283, 32'h00200303, 32'h006283b3, 32'h007001a3};
      int cyc, re_cnt;
      reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         re_cnt = 0;
         cyc = 0;
         do begin
            tick();
            cyc++;
            if (flash_re) re_cnt++;
         end while (!instr_valid && cyc < 40);
         if (i == 3) fetch_en = 1'b0;
         checks++;
         if (instr !== exp_i[i] || instr_pc !== 24'(4 * i)) begin
            errors++;
            $display("FAIL stream_instr%0d: instr=%h pc=%h, required %h pc=%h",
                     i, instr, instr_pc, exp_i[i], 24'(4 * i));
         end
         checks++;
         if (cyc != 13 || re_cnt != 12) begin
            errors++;
            $display("FAIL stream_timing%0d: cycles=%0d re_cycles=%0d, required 13 and 12", i, cyc, re_cnt);
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_idle: busy=%b valid=%b, required 0 0", busy, instr_valid);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      do_reset();
      fetch_en = 1'b1; instr_ready = 1'b0;
      wait_valid(1'b0, cyc);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (instr !== 32'h00100283 || instr_pc !== 24'h0 || instr_valid !== 1'b1 || flash_re !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable%0d: instr=%h pc=%h v=%b re=%b, required 00100283 000000 1 0",
                     i, instr, instr_pc, instr_valid, flash_re);
         end
      end
      instr_ready = 1'b1;
      tick();
      checks++;
      if (flash_re !== 1'b1 || flash_addr !== 24'h4 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_fetch: re=%b addr=%h v=%b, required 1 000004 0", flash_re, flash_addr, instr_valid);
      end
      fetch_en = 1'b0;
      wait_valid(1'b0, cyc);
      checks++;
      if (instr !== 32'h00200303 || instr_pc !== 24'h4) begin
         errors++;
         $display("FAIL fetch_en_drop_completes: instr=%h pc=%h, required 00200303 000004", instr, instr_pc);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_transfer: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_redirect_mid();
      int cyc;
      do_reset();
      fetch_en = 1'b1; instr_ready = 1'b1;
      repeat (7) tick();
      checks++;
      if (flash_addr !== 24'h2) begin
         errors++;
         $display("FAIL third_byte_addr: addr=%h, required 000002", flash_addr);
      end
      redirect = 1'b1; redirect_addr = 24'h000008;
      tick();
      redirect = 1'b0;
      checks++;
      if (flash_re !== 1'b1 || flash_addr !== 24'h8) begin
         errors++;
         $display("FAIL redirect_addr: re=%b addr=%h, required 1 000008", flash_re, flash_addr);
      end
      wait_valid(1'b0, cyc);
      checks++;
      if (instr !== 32'h006283b3 || instr_pc !== 24'h8 || cyc != 12) begin
         errors++;
         $display("FAIL redirect_instr: instr=%h pc=%h cycles=%0d, required 006283b3 000008 12",
                  instr, instr_pc, cyc);
      end
      fetch_en = 1'b0;
      tick();
   endtask

   task automatic test_redirect_on_transfer();
      int cyc;
      do_reset();
      fetch_en = 1'b1; instr_ready = 1'b1;
      wait_valid(1'b0, cyc);
      checks++;
      if (instr !== 32'h00100283 || instr_pc !== 24'h0) begin
         errors++;
         $display("FAIL rot_first: instr=%h pc=%h, required 00100283 000000", instr, instr_pc);
      end
      redirect = 1'b1; redirect_addr = 24'h00000C;
      tick();
      redirect = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || flash_addr !== 24'hC) begin
         errors++;
         $display("FAIL rot_restart: v=%b addr=%h, required 0 00000c", instr_valid, flash_addr);
      end
      wait_valid(1'b0, cyc);
      checks++;
      if (instr !== 32'h007001a3 || instr_pc !== 24'hC) begin
         errors++;
         $display("FAIL rot_next: instr=%h pc=%h, required 007001a3 00000c", instr, instr_pc);
      end
      fetch_en = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      int cyc;
      do_reset();
      fetch_en = 1'b1; instr_ready = 1'b1;
      wait_valid(1'b1, cyc);
      checks++;
      if (w_instr !== 32'h12345678 || w_instr_pc !== 24'hFFFFFE) begin
         errors++;
         $display("FAIL wrap_instr: instr=%h pc=%h, required 12345678 fffffe", w_instr, w_instr_pc);
      end
      tick();
      checks++;
      if (w_flash_re !== 1'b1 || w_flash_addr !== 24'h000002) begin
         errors++;
         $display("FAIL wrap_next_pc: re=%b addr=%h, required 1 000002", w_flash_re, w_flash_addr);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      do_reset();
      fetch_en = 1'b1; instr_ready = 1'b1;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({flash_re, flash_addr, instr, instr_pc, instr_valid, busy} !== '0) begin
         errors++;
         $display("FAIL reset_mid_read: re=%b addr=%h instr=%h pc=%h v=%b busy=%b, required all 0",
                  flash_re, flash_addr, instr, instr_pc, instr_valid, busy);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (flash_re !== 1'b1 || flash_addr !== 24'h0 || w_flash_addr !== 24'hFFFFFE) begin
         errors++;
         $display("FAIL restart_after_read_reset: re=%b addr=%h wrap_addr=%h, required 1 000000 fffffe",
                  flash_re, flash_addr, w_flash_addr);
      end
      instr_ready = 1'b0;
      wait_valid(1'b0, cyc);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({flash_re, flash_addr, instr, instr_pc, instr_valid, busy} !== '0 ||
          {w_instr, w_instr_pc, w_instr_valid, w_busy} !== '0) begin
         errors++;
         $display("FAIL reset_mid_hold: instr=%h v=%b busy=%b wrap_instr=%h wrap_pc=%h, required all 0",
                  instr, instr_valid, busy, w_instr, w_instr_pc);
      end
      reset = 1'b0; instr_ready = 1'b1;
      tick();
      checks++;
      if (flash_re !== 1'b1 || flash_addr !== 24'h0 || w_flash_addr !== 24'hFFFFFE) begin
         errors++;
         $display("FAIL restart_after_hold_reset: re=%b addr=%h wrap_addr=%h, required 1 000000 fffffe",
                  flash_re, flash_addr, w_flash_addr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_mid();
      test_redirect_on_transfer();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
